// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: D/E operand bypass selects,
// Tuse/Tnew and MDU-busy stall, MDU occupancy countdown and a saturating stall counter.
`timescale 1ns/1ps
module hazard_fwd_unit #(
    parameter int NSRC    = 2,
    parameter int TW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CW      = 4,
    parameter int SCW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*5-1:0]    D_A,
    input  logic [NSRC*TW-1:0]   D_Tuse,
    input  logic                 D_mdu,
    input  logic [NSRC*5-1:0]    E_A,
    input  logic [4:0]           E_A3,
    input  logic [TW-1:0]        E_Tnew,
    input  logic                 E_RegWrite,
    input  logic [4:0]           M_A3,
    input  logic [TW-1:0]        M_Tnew,
    input  logic                 M_RegWrite,
    input  logic [4:0]           W_A3,
    input  logic                 W_RegWrite,
    input  logic                 E_md_start,
    input  logic                 E_md_div,
    input  logic                 stat_clr,
    output logic [NSRC*2-1:0]    D_fwd_sel,
    output logic [NSRC*2-1:0]    E_fwd_sel,
    output logic                 stall,
    output logic                 flush_E,
    output logic                 md_busy,
    output logic [SCW-1:0]       stall_cnt
);

    logic [CW-1:0]   cnt;
    logic [NSRC-1:0] op_stall;
    logic            mdu_stall;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [4:0]    da;
        logic [4:0]    ea;
        logic [TW-1:0] tuse;
        logic          d_hit_e, d_hit_m, d_hit_w;
        logic          e_hit_m, e_hit_w;
        logic [1:0]    d_sel;
        logic [1:0]    e_sel;

        assign da   = D_A[5*i +: 5];
        assign ea   = E_A[5*i +: 5];
        assign tuse = D_Tuse[TW*i +: TW];

        assign d_hit_e = (da != 5'd0) && (da == E_A3) && E_RegWrite;
        assign d_hit_m = (da != 5'd0) && (da == M_A3) && M_RegWrite;
        assign d_hit_w = (da != 5'd0) && (da == W_A3) && W_RegWrite;
        assign e_hit_m = (ea != 5'd0) && (ea == M_A3) && M_RegWrite;
        assign e_hit_w = (ea != 5'd0) && (ea == W_A3) && W_RegWrite;

        // Nearest matching stage owns the operand; a not-yet-ready producer blocks older ones.
        always_comb begin
            d_sel = 2'b00;
            if (d_hit_e)
                d_sel = (E_Tnew == '0) ? 2'b11 : 2'b00;
            else if (d_hit_m)
                d_sel = (M_Tnew == '0) ? 2'b10 : 2'b00;
            else if (d_hit_w)
                d_sel = 2'b01;
        end

        always_comb begin
            e_sel = 2'b00;
            if (e_hit_m)
                e_sel = (M_Tnew == '0) ? 2'b10 : 2'b00;
            else if (e_hit_w)
                e_sel = 2'b01;
        end

        assign D_fwd_sel[2*i +: 2] = d_sel;
        assign E_fwd_sel[2*i +: 2] = e_sel;
        assign op_stall[i] = (d_hit_e && (E_Tnew > tuse)) || (d_hit_m && (M_Tnew > tuse));
    end

    assign md_busy   = (cnt != '0);
    assign mdu_stall = D_mdu & (md_busy | E_md_start);
    assign stall     = (|op_stall) | mdu_stall;
    assign flush_E   = stall;

    // A start while the unit is still counting is dropped, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (E_md_start && (cnt == '0))
            cnt <= E_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stat_clr)
            stall_cnt <= '0;
        else if (stall && !(&stall_cnt))
            stall_cnt <= stall_cnt + SCW'(1);
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios then randomized traffic
// against a cycle-indexed reference model.
`timescale 1ns/1ps
module tb_hazard_fwd_unit;
    localparam int NSRC = 2, TW = 2, MUL_LAT = 5, DIV_LAT = 10, CW = 4, SCW = 4;
    localparam int SAT = (1 << SCW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NSRC*5-1:0]  D_A, E_A;
    logic [NSRC*TW-1:0] D_Tuse;
    logic D_mdu, E_RegWrite, M_RegWrite, W_RegWrite, E_md_start, E_md_div, stat_clr;
    logic [4:0] E_A3, M_A3, W_A3;
    logic [TW-1:0] E_Tnew, M_Tnew;
    logic [NSRC*2-1:0] D_fwd_sel, E_fwd_sel;
    logic stall, flush_E, md_busy;
    logic [SCW-1:0] stall_cnt;

    int errors = 0, checks = 0;
    int cyc = 0;
    int busy_last = -1;
    int stc = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.NSRC(NSRC), .TW(TW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT),
                      .CW(CW), .SCW(SCW)) dut (
        .clk(clk), .rst_n(rst_n), .D_A(D_A), .D_Tuse(D_Tuse), .D_mdu(D_mdu),
        .E_A(E_A), .E_A3(E_A3), .E_Tnew(E_Tnew), .E_RegWrite(E_RegWrite),
        .M_A3(M_A3), .M_Tnew(M_Tnew), .M_RegWrite(M_RegWrite),
        .W_A3(W_A3), .W_RegWrite(W_RegWrite), .E_md_start(E_md_start),
        .E_md_div(E_md_div), .stat_clr(stat_clr), .D_fwd_sel(D_fwd_sel),
        .E_fwd_sel(E_fwd_sel), .stall(stall), .flush_E(flush_E),
        .md_busy(md_busy), .stall_cnt(stall_cnt));

    function automatic bit hit(logic [4:0] a, logic [4:0] a3, logic we);
        return (a != 5'd0) && (a == a3) && (we == 1'b1);
    endfunction

    function automatic logic [1:0] exp_dsel(int i);
        logic [4:0] a;
        a = D_A[5*i +: 5];
        if (hit(a, E_A3, E_RegWrite)) return (E_Tnew == 0) ? 2'b11 : 2'b00;
        if (hit(a, M_A3, M_RegWrite)) return (M_Tnew == 0) ? 2'b10 : 2'b00;
        if (hit(a, W_A3, W_RegWrite)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_esel(int i);
        logic [4:0] a;
        a = E_A[5*i +: 5];
        if (hit(a, M_A3, M_RegWrite)) return (M_Tnew == 0) ? 2'b10 : 2'b00;
        if (hit(a, W_A3, W_RegWrite)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_busy();
        return (rst_n == 1'b1) && (cyc <= busy_last);
    endfunction

    function automatic bit exp_stall();
        bit s;
        int tuse;
        logic [4:0] a;
        s = (D_mdu == 1'b1) && (model_busy() || (E_md_start == 1'b1));
        for (int i = 0; i < NSRC; i++) begin
            a = D_A[5*i +: 5];
            tuse = int'(D_Tuse[TW*i +: TW]);
            if (hit(a, E_A3, E_RegWrite) && int'(E_Tnew) > tuse) s = 1'b1;
            if (hit(a, M_A3, M_RegWrite) && int'(M_Tnew) > tuse) s = 1'b1;
        end
        return s;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NSRC; i++) begin
            chk($sformatf("D_fwd_sel[%0d] cyc%0d", i, cyc), 32'(D_fwd_sel[2*i +: 2]), 32'(exp_dsel(i)));
            chk($sformatf("E_fwd_sel[%0d] cyc%0d", i, cyc), 32'(E_fwd_sel[2*i +: 2]), 32'(exp_esel(i)));
        end
        chk($sformatf("stall cyc%0d", cyc), 32'(stall), 32'(exp_stall()));
        chk($sformatf("flush_E cyc%0d", cyc), 32'(flush_E), 32'(exp_stall()));
        chk($sformatf("md_busy cyc%0d", cyc), 32'(md_busy), 32'(model_busy()));
        chk($sformatf("stall_cnt cyc%0d", cyc), 32'(stall_cnt), 32'(stc));
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        bit s;
        @(negedge clk);
        check_all();
        @(posedge clk);
        s = exp_stall();
        if (!rst_n) begin
            stc = 0;
            busy_last = -1;
        end else begin
            if (stat_clr) stc = 0;
            else if (s && stc < SAT) stc++;
            if (E_md_start && !model_busy())
                busy_last = cyc + (E_md_div ? DIV_LAT : MUL_LAT);
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        D_A = '0; E_A = '0; D_Tuse = '0; D_mdu = 0;
        E_A3 = '0; E_Tnew = '0; E_RegWrite = 0;
        M_A3 = '0; M_Tnew = '0; M_RegWrite = 0;
        W_A3 = '0; W_RegWrite = 0;
        E_md_start = 0; E_md_div = 0; stat_clr = 0;
    endtask

    initial begin
        idle_inputs();
        #2;
        chk("reset md_busy", 32'(md_busy), 32'd0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // D forwarding from E, then an E-not-ready stall
        D_A = {5'd0, 5'd8}; E_A3 = 5'd8; E_RegWrite = 1; E_Tnew = 0; D_Tuse = '0;
        #1;
        chk("t1 D_fwd_sel E", 32'(D_fwd_sel[1:0]), 32'd3);
        chk("t1 no stall", 32'(stall), 32'd0);
        tick();
        E_Tnew = 1;
        #1;
        chk("t1 stall", 32'(stall), 32'd1);
        chk("t1 flush_E", 32'(flush_E), 32'd1);
        tick();

        // E forwarding priority M > W > GRF
        idle_inputs();
        E_A = {5'd9, 5'd0}; M_A3 = 5'd9; W_A3 = 5'd9; M_RegWrite = 1; W_RegWrite = 1;
        #1;
        chk("t2 E_fwd_sel M", 32'(E_fwd_sel[3:2]), 32'd2);
        tick();
        M_RegWrite = 0;
        #1;
        chk("t2 E_fwd_sel W", 32'(E_fwd_sel[3:2]), 32'd1);
        tick();
        M_A3 = 0; W_A3 = 0; E_A = '0;
        #1;
        chk("t2 E_fwd_sel GRF", 32'(E_fwd_sel[3:2]), 32'd0);
        tick();

        // Divide: busy exactly DIV_LAT cycles, D_mdu stalls across start + busy
        idle_inputs();
        D_mdu = 1; E_md_start = 1; E_md_div = 1;
        #1;
        chk("div start stall", 32'(stall), 32'd1);
        tick();
        E_md_start = 0;
        for (int k = 1; k <= DIV_LAT; k++) begin
            chk($sformatf("div busy k=%0d", k), 32'(md_busy), 32'd1);
            chk($sformatf("div stall k=%0d", k), 32'(stall), 32'd1);
            tick();
        end
        chk("div done busy", 32'(md_busy), 32'd0);
        chk("div done stall", 32'(stall), 32'd0);

        // Multiply with an ignored restart on the 3rd busy cycle
        idle_inputs();
        E_md_start = 1;
        tick();
        for (int k = 1; k <= MUL_LAT; k++) begin
            chk($sformatf("mul busy k=%0d", k), 32'(md_busy), 32'd1);
            E_md_start = (k == 3);
            E_md_div = (k == 3);
            tick();
        end
        E_md_start = 0; E_md_div = 0;
        chk("mul done busy", 32'(md_busy), 32'd0);
        tick();

        // Asynchronous reset in the middle of a divide
        idle_inputs();
        D_mdu = 1; E_md_start = 1; E_md_div = 1;
        tick();
        E_md_start = 0;
        for (int k = 0; k < 4; k++) tick();
        chk("pre-reset busy", 32'(md_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        busy_last = -1; stc = 0;
        #1;
        chk("async reset busy", 32'(md_busy), 32'd0);
        chk("async reset stall", 32'(stall), 32'd0);
        chk("async reset stall_cnt", 32'(stall_cnt), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("post-reset busy", 32'(md_busy), 32'd0);

        // Stall counter saturation and clear-with-stall
        idle_inputs();
        D_A = {5'd0, 5'd8}; E_A3 = 5'd8; E_RegWrite = 1; E_Tnew = 2; D_Tuse = '0;
        for (int k = 0; k < 20; k++) tick();
        chk("stall_cnt saturated", 32'(stall_cnt), 32'(SAT));
        stat_clr = 1;
        tick();
        chk("stat_clr wins", 32'(stall_cnt), 32'd0);
        stat_clr = 0;
        tick();
        chk("count after clr", 32'(stall_cnt), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NSRC; i++) begin
                D_A[5*i +: 5] = 5'($urandom_range(0, 3));
                E_A[5*i +: 5] = 5'($urandom_range(0, 3));
                D_Tuse[TW*i +: TW] = TW'($urandom_range(0, 3));
            end
            E_A3 = 5'($urandom_range(0, 3));
            M_A3 = 5'($urandom_range(0, 3));
            W_A3 = 5'($urandom_range(0, 3));
            E_Tnew = TW'($urandom_range(0, 3));
            M_Tnew = TW'($urandom_range(0, 2));
            E_RegWrite = 1'($urandom_range(0, 1));
            M_RegWrite = 1'($urandom_range(0, 1));
            W_RegWrite = 1'($urandom_range(0, 1));
            D_mdu = ($urandom_range(0, 2) == 0);
            E_md_start = ($urandom_range(0, 7) == 0);
            E_md_div = 1'($urandom_range(0, 1));
            stat_clr = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline; successor to the E-stage-only forwarding selector.
- Generates forwarding selects for NSRC source operands in both D and E.
- Generates the D-stage stall (Tuse/Tnew rule plus multiply/divide busy) and tracks the multi-cycle MDU occupancy internally.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- NSRC, 2, source operands per instruction (rs, rt, ...).
- TW, 2, width of Tuse/Tnew fields.
- MUL_LAT, 5, busy cycles after a multiply start.
- DIV_LAT, 10, busy cycles after a divide start; must be >= MUL_LAT and < 2^CW.
- CW, 4, MDU countdown width.
- SCW, 16, stall counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- D_A  in  NSRC*5  D-stage source register addresses; operand i is at bits [5i+4:5i].
- D_Tuse  in  NSRC*TW  cycles until D operand i is consumed.
- D_mdu  in  1  D instruction reads or writes HI/LO or starts the MDU.
- E_A  in  NSRC*5  E-stage source register addresses.
- E_A3  in  5  E-stage destination register.
- E_Tnew  in  TW  cycles until the E result is ready.
- E_RegWrite  in  1  E-stage write enable.
- M_A3  in  5  M-stage destination register.
- M_Tnew  in  TW  cycles until the M result is ready.
- M_RegWrite  in  1  M-stage write enable.
- W_A3  in  5  W-stage destination register (W result is always ready).
- W_RegWrite  in  1  W-stage write enable.
- E_md_start  in  1  one-cycle MDU start pulse from E.
- E_md_div  in  1  qualifies E_md_start: 1 = divide, 0 = multiply.
- stat_clr  in  1  synchronous clear of stall_cnt.
- D_fwd_sel  out  NSRC*2  per-operand D select: 00 GRF, 01 W, 10 M, 11 E.
- E_fwd_sel  out  NSRC*2  per-operand E select: 00 GRF, 01 W, 10 M (11 never driven).
- stall  out  1  freeze PC/F/D this cycle.
- flush_E  out  1  load a bubble into E this cycle (equals stall).
- md_busy  out  1  MDU occupied.
- stall_cnt  out  SCW  saturating count of stall cycles.

Behaviour:
- Match rule: a source address A matches stage X when A != 0, A == X_A3, and X_RegWrite = 1.
- Forward selection, D operand i (combinational):
  - Highest priority: E match with E_Tnew == 0 -> 11.
  - Else M match with M_Tnew == 0 -> 10.
  - Else W match -> 01.
  - Else 00.
  - The nearest stage always wins. If E matches with Tnew > 0, lower stages are not consulted; the stall covers the hazard.
- Forward selection, E operand i: M match with M_Tnew == 0 -> 10, else W match -> 01, else 00.
- Data stall:
  - Asserted for operand i when it matches E and E_Tnew > D_Tuse[i].
  - Or when it matches M and M_Tnew > D_Tuse[i].
  - Comparison is unsigned over TW bits.
  - Address 0 never stalls and never forwards.
- MDU stall: D_mdu & (md_busy | E_md_start).
- stall = OR of all data stalls and the MDU stall. flush_E = stall. Both are combinational.
- MDU countdown register cnt[CW-1:0]:
  - On E_md_start with cnt == 0: load DIV_LAT if E_md_div, else MUL_LAT.
  - Else if cnt != 0: cnt - 1.
  - E_md_start while cnt != 0 is ignored; cnt keeps counting down.
  - md_busy = (cnt != 0), registered. It rises the cycle after the start and stays high exactly MUL_LAT or DIV_LAT cycles.
- stall_cnt, updated on the rising edge:
  - stat_clr -> 0. stat_clr has priority over increment.
  - Else if stall and stall_cnt != all-ones -> +1.
  - Saturates at 2^SCW-1.
- Reset (rst_n low, asynchronous):
  - cnt = 0, md_busy = 0, stall_cnt = 0.
  - Combinational outputs follow their inputs.
  - Reset during an MDU operation aborts it immediately; md_busy drops without waiting for a clock.
- Simultaneous events:
  - Start pulse and D_mdu in the same cycle -> stall.
  - stat_clr together with stall -> counter reads 0 next cycle.

Test Plan:
- D_A[0]=8, E_A3=8, E_RegWrite=1, E_Tnew=0 -> D_fwd_sel[1:0]=11, stall=0. Change E_Tnew=1, D_Tuse[0]=0 -> stall=1, flush_E=1.
- E_A[1]=9, M_A3=9, W_A3=9, M_Tnew=0, both RegWrite=1 -> E_fwd_sel[3:2]=10. Set M_RegWrite=0 -> 01. Set both A3=0 with E_A[1]=0 -> 00.
- E_md_start=1, E_md_div=1 for one cycle -> md_busy=1 for exactly 10 cycles. D_mdu=1 throughout -> stall=1 on the start cycle and all 10 busy cycles, then 0.
- Multiply start, then a second start on the 3rd busy cycle -> second start ignored, md_busy lasts 5 cycles total.
- Assert rst_n=0 mid-divide (cnt=6) -> md_busy=0 immediately, stall drops; after release, no residual busy.
- SCW=4 build: hold a data stall 20 cycles -> stall_cnt=15 (saturated). Pulse stat_clr with stall high -> 0 next cycle, then 1.
